// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end. Owns the program counter that addresses a
// combinational instruction memory and the IF/ID pipeline register that
// captures the decoded fields the memory returns for that address.
//
// Control is a three-state FSM:
//   BOOT    - one cycle after reset release; PC held at 0, IF/ID gets a bubble
//   RUN     - per-edge priority: halt > redirect > stall > advance
//   HALTED  - PC frozen, IF/ID held as a bubble, left only through rst_n
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       hold PC and IF/ID (RUN only)
//   redirect, redirectAddr      load PC with target, flush IF/ID (beats stall)
//   halt                        stop fetching; sticky until reset
//   pcAddr                      instruction-memory address (= PC register)
//   imRs/imRt/imRd/imSa/imFunc  fields returned by memory for pcAddr
//   idRs/idRt/idRd/idSa/idFunc  IF/ID latched fields
//   idPcNext                    IF/ID latched PC+1 (wraps, no carry out)
//   idValid                     IF/ID holds a real instruction
//   halted                      registered; rises on the edge entering HALTED
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 5,
    parameter int FUNC_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectAddr,
    input  logic              halt,
    output logic [ADDR_W-1:0] pcAddr,
    input  logic [REG_W-1:0]  imRs,
    input  logic [REG_W-1:0]  imRt,
    input  logic [REG_W-1:0]  imRd,
    input  logic [REG_W-1:0]  imSa,
    input  logic [FUNC_W-1:0] imFunc,
    output logic [REG_W-1:0]  idRs,
    output logic [REG_W-1:0]  idRt,
    output logic [REG_W-1:0]  idRd,
    output logic [REG_W-1:0]  idSa,
    output logic [FUNC_W-1:0] idFunc,
    output logic [ADDR_W-1:0] idPcNext,
    output logic              idValid,
    output logic              halted
);

    // -----------------------------------------------------------------------
    // Types
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // What the IF/ID register does on the coming edge. Every IF/ID flop
    // follows the same command, so it is decoded once here.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_t;

    localparam int N_FLD = 4;   // rs, rt, rd, sa share one width

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    state_t                          state_q, state_d;
    ifid_op_t                        ifid_op;

    logic [ADDR_W-1:0]               pc_q, pc_d;
    logic [ADDR_W-1:0]               pc_inc;
    logic                            halted_q, halted_d;

    logic [FUNC_W-1:0]               func_q, func_d;
    logic [ADDR_W-1:0]               pc_next_q, pc_next_d;
    logic                            valid_q, valid_d;

    logic [N_FLD-1:0][REG_W-1:0]     im_fld;
    logic [N_FLD-1:0][REG_W-1:0]     id_fld;

    // Truncated to ADDR_W so 2**ADDR_W-1 wraps to 0 with no carry.
    assign pc_inc = pc_q + ADDR_W'(1);

    // Register-specifier fields in a fixed order: 0=rs 1=rt 2=rd 3=sa
    assign im_fld = {imSa, imRd, imRt, imRs};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = halt ? ST_HALTED : ST_RUN;
            ST_RUN:    state_d = halt ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_BOOT;   // unreachable encoding: restart
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic (PC update, IF/ID command, halted flag)
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        ifid_op  = IFID_HOLD;
        halted_d = halted_q;
        case (state_q)
            ST_BOOT: begin
                // stall/redirect are deliberately ignored in this cycle
                pc_d     = '0;
                ifid_op  = IFID_BUBBLE;
                halted_d = halt;
            end
            ST_RUN: begin
                if (halt) begin
                    ifid_op  = IFID_BUBBLE;
                    halted_d = 1'b1;
                end else if (redirect) begin
                    // Redirect wins over stall: the stalled instruction is on
                    // the wrong path anyway.
                    pc_d    = redirectAddr;
                    ifid_op = IFID_BUBBLE;
                end else if (stall) begin
                    ifid_op = IFID_HOLD;
                end else begin
                    pc_d    = pc_inc;
                    ifid_op = IFID_LOAD;
                end
            end
            ST_HALTED: begin
                ifid_op  = IFID_BUBBLE;
                halted_d = 1'b1;
            end
            default: begin
                pc_d     = '0;
                ifid_op  = IFID_BUBBLE;
                halted_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC and halted flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign pcAddr = pc_q;
    assign halted = halted_q;

    // -----------------------------------------------------------------------
    // IF/ID register: register-specifier fields
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_FLD; gi++) begin : g_fld
            logic [REG_W-1:0] fld_q, fld_d;

            always_comb begin
                fld_d = fld_q;
                case (ifid_op)
                    IFID_LOAD:   fld_d = im_fld[gi];
                    IFID_BUBBLE: fld_d = '0;
                    default:     fld_d = fld_q;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fld_q <= '0;
                end else begin
                    fld_q <= fld_d;
                end
            end

            assign id_fld[gi] = fld_q;
        end
    endgenerate

    assign idRs = id_fld[0];
    assign idRt = id_fld[1];
    assign idRd = id_fld[2];
    assign idSa = id_fld[3];

    // -----------------------------------------------------------------------
    // IF/ID register: function field, PC+1 and valid
    // -----------------------------------------------------------------------
    always_comb begin
        func_d    = func_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        case (ifid_op)
            IFID_LOAD: begin
                func_d    = imFunc;
                pc_next_d = pc_inc;     // wrapped PC+1 of the captured instr
                valid_d   = 1'b1;
            end
            IFID_BUBBLE: begin
                func_d    = '0;
                pc_next_d = '0;
                valid_d   = 1'b0;
            end
            default: begin
                func_d    = func_q;
                pc_next_d = pc_next_q;
                valid_d   = valid_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q    <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            func_q    <= func_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign idFunc   = func_q;
    assign idPcNext = pc_next_q;
    assign idValid  = valid_q;

endmodule
